// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for memory_arbiter: FSM state, response owner,
// byte-lane merge for read-modify-write, and byte-to-word address translation.
package mem_arb_pkg;

  typedef enum logic {ST_IDLE, ST_RMW_WRITE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  // Bit positions inside the selector's one-hot grant vector.
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

  localparam logic [3:0] BE_NONE = 4'h0;
  localparam logic [3:0] BE_FULL = 4'hF;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int n = 0; n < 4; n++) begin
      if (be[n]) merged[8*n +: 8] = new_word[8*n +: 8];
    end
    return merged;
  endfunction

  function automatic logic [31:0] to_word_addr(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Two-way request selector producing a one-hot grant. Fixed priority (D over I)
// by default; alternates on contention when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arb_select
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       i_Clock,
  input  logic       i_Reset,
`endif
  input  logic       i_IReq,
  input  logic       i_DReq,
  input  logic       i_Block,
  output logic [1:0] o_Grant
);

  logic d_wins;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic contested;
  logic prio_d_q;

  assign contested = i_IReq && i_DReq && !i_Block;

  // The pointer only moves when both ports actually competed for the cycle.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)        prio_d_q <= 1'b1;
    else if (contested) prio_d_q <= !prio_d_q;
  end

  assign d_wins = !contested || prio_d_q;
`else
  assign d_wins = 1'b1;
`endif

  always_comb begin
    o_Grant = '0;
    if (!i_Block) begin
      if (i_DReq && d_wins) o_Grant[GNT_D] = 1'b1;
      else if (i_IReq)      o_Grant[GNT_I] = 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port word memory between fetch and load/store ports, with
// RMW sequencing for sub-word stores. Option macro: MEM_ARB_ROUND_ROBIN_EN.
module memory_arbiter
  import mem_arb_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_IReq,
  input  logic [31:0] i_IAddress,
  output logic        o_IGrant,
  output logic        o_IValid,
  output logic [31:0] o_IData,
  input  logic        i_DReq,
  input  logic        i_DWrite,
  input  logic [31:0] i_DAddress,
  input  logic [3:0]  i_DByteEnable,
  input  logic [31:0] i_DData,
  output logic        o_DGrant,
  output logic        o_DValid,
  output logic [31:0] o_DData,
  output logic        o_MemWriteEnable,
  output logic [31:0] o_MemAddress,
  output logic [31:0] o_MemDataIn,
  input  logic [31:0] i_MemDataOut
);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [31:0] addr_q;
  logic [31:0] rmw_addr_q;
  logic [3:0]  rmw_be_q;
  logic [31:0] rmw_data_q;
  logic [1:0]  grant;
  logic        partial_store;

  // Reset is folded into the block so no grant can leak out while it is held.
  mem_arb_select u_select (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
`endif
    .i_IReq  (i_IReq),
    .i_DReq  (i_DReq),
    .i_Block ((state_q == ST_RMW_WRITE) || i_Reset),
    .o_Grant (grant)
  );

  assign o_IGrant      = grant[GNT_I];
  assign o_DGrant      = grant[GNT_D];
  assign partial_store = i_DWrite && (i_DByteEnable != BE_NONE) && (i_DByteEnable != BE_FULL);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_d          = state_q;
    owner_d          = OWN_NONE;
    o_MemWriteEnable = 1'b0;
    o_MemAddress     = addr_q;
    o_MemDataIn      = '0;
    case (state_q)
      ST_RMW_WRITE: begin
        o_MemWriteEnable = 1'b1;
        o_MemAddress     = rmw_addr_q;
        o_MemDataIn      = byte_merge(i_MemDataOut, rmw_data_q, rmw_be_q);
        owner_d          = OWN_D;
        state_d          = ST_IDLE;
      end
      default: begin
        if (grant[GNT_D]) begin
          o_MemAddress = to_word_addr(i_DAddress);
          owner_d      = OWN_D;
          if (i_DWrite && (i_DByteEnable == BE_FULL)) begin
            o_MemWriteEnable = 1'b1;
            o_MemDataIn      = i_DData;
          end else if (partial_store) begin
            // The ack waits for the write half of the sequence.
            owner_d = OWN_NONE;
            state_d = ST_RMW_WRITE;
          end
        end else if (grant[GNT_I]) begin
          o_MemAddress = to_word_addr(i_IAddress);
          owner_d      = OWN_I;
        end
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      rmw_addr_q <= '0;
      rmw_be_q   <= '0;
      rmw_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= o_MemAddress;
      if (grant[GNT_D] && partial_store) begin
        rmw_addr_q <= to_word_addr(i_DAddress);
        rmw_be_q   <= i_DByteEnable;
        rmw_data_q <= i_DData;
      end
    end
  end

  assign o_IValid = (owner_q == OWN_I);
  assign o_DValid = (owner_q == OWN_D);
  assign o_IData  = (owner_q == OWN_I) ? i_MemDataOut : '0;
  assign o_DData  = (owner_q == OWN_D) ? i_MemDataOut : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a 1-cycle-latency word memory model.
// Contention expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_memory_arbiter;

  logic        i_Clock;
  logic        i_Reset;
  logic        i_IReq;
  logic [31:0] i_IAddress;
  logic        o_IGrant;
  logic        o_IValid;
  logic [31:0] o_IData;
  logic        i_DReq;
  logic        i_DWrite;
  logic [31:0] i_DAddress;
  logic [3:0]  i_DByteEnable;
  logic [31:0] i_DData;
  logic        o_DGrant;
  logic        o_DValid;
  logic [31:0] o_DData;
  logic        o_MemWriteEnable;
  logic [31:0] o_MemAddress;
  logic [31:0] o_MemDataIn;
  logic [31:0] i_MemDataOut;

  int n_vectors;
  int n_miscompares;

  logic [31:0] mem [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [31:0] bd_data;

  memory_arbiter dut (
    .i_Clock          (i_Clock),
    .i_Reset          (i_Reset),
    .i_IReq           (i_IReq),
    .i_IAddress       (i_IAddress),
    .o_IGrant         (o_IGrant),
    .o_IValid         (o_IValid),
    .o_IData          (o_IData),
    .i_DReq           (i_DReq),
    .i_DWrite         (i_DWrite),
    .i_DAddress       (i_DAddress),
    .i_DByteEnable    (i_DByteEnable),
    .i_DData          (i_DData),
    .o_DGrant         (o_DGrant),
    .o_DValid         (o_DValid),
    .o_DData          (o_DData),
    .o_MemWriteEnable (o_MemWriteEnable),
    .o_MemAddress     (o_MemAddress),
    .o_MemDataIn      (o_MemDataIn),
    .i_MemDataOut     (i_MemDataOut)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  // Memory decodes address bits [15:0]; read-first, one cycle latency.
  always @(posedge i_Clock) begin
    if (o_MemWriteEnable) mem[o_MemAddress[15:0]] <= o_MemDataIn;
    else if (bd_we)       mem[bd_addr] <= bd_data;
    i_MemDataOut <= mem[o_MemAddress[15:0]];
  end

  function automatic logic d_expected(input int slot);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return (slot % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    @(negedge i_Clock);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge i_Clock);
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge i_Clock);
    i_IReq = 1'b1; i_DReq = 1'b1; i_IAddress = 32'h100; i_DAddress = 32'h40;
    #1;
    n_vectors++; if (o_IGrant !== 1'b0) begin n_miscompares++; $display("FAIL reset_igrant: got %0h want 0", o_IGrant); end
    n_vectors++; if (o_DGrant !== 1'b0) begin n_miscompares++; $display("FAIL reset_dgrant: got %0h want 0", o_DGrant); end
    n_vectors++; if ({o_IValid, o_DValid} !== 2'b00) begin n_miscompares++; $display("FAIL reset_valids: got %0b want 00", {o_IValid, o_DValid}); end
    n_vectors++; if (o_MemWriteEnable !== 1'b0) begin n_miscompares++; $display("FAIL reset_we: got %0h want 0", o_MemWriteEnable); end
    n_vectors++; if (o_MemAddress !== 32'h0) begin n_miscompares++; $display("FAIL reset_addr: got %h want 0", o_MemAddress); end
    n_vectors++; if ({o_IData, o_DData, o_MemDataIn} !== 96'h0) begin n_miscompares++; $display("FAIL reset_data: got %h %h %h want 0", o_IData, o_DData, o_MemDataIn); end
    @(negedge i_Clock);
    i_IReq = 1'b0; i_DReq = 1'b0;
    i_Reset = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge i_Clock);
    i_IReq = 1'b1; i_IAddress = 32'h100;
    #1;
    n_vectors++; if (o_IGrant !== 1'b1) begin n_miscompares++; $display("FAIL fetch_grant: got %0h want 1", o_IGrant); end
    n_vectors++; if (o_MemAddress !== 32'h40) begin n_miscompares++; $display("FAIL fetch_addr: got %h want 00000040", o_MemAddress); end
    @(negedge i_Clock);
    i_IReq = 1'b0;
    #1;
    n_vectors++; if (o_IValid !== 1'b1) begin n_miscompares++; $display("FAIL fetch_valid: got %0h want 1", o_IValid); end
    n_vectors++; if (o_IData !== 32'hDEADBEEF) begin n_miscompares++; $display("FAIL fetch_data: got %h want deadbeef", o_IData); end
    n_vectors++; if (o_MemAddress !== 32'h40) begin n_miscompares++; $display("FAIL idle_addr_hold: got %h want 00000040", o_MemAddress); end
    n_vectors++; if (o_MemWriteEnable !== 1'b0) begin n_miscompares++; $display("FAIL idle_we: got %0h want 0", o_MemWriteEnable); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [0:3];
    exp_data[0] = 32'h1111_0000; exp_data[1] = 32'h2222_0001;
    exp_data[2] = 32'h3333_0002; exp_data[3] = 32'h4444_0003;
    for (int i = 0; i <= 4; i++) begin
      @(negedge i_Clock);
      i_IReq = (i < 4); i_IAddress = 32'(4 * i);
      #1;
      if (i > 0) begin
        n_vectors++; if (o_IValid !== 1'b1) begin n_miscompares++; $display("FAIL b2b_valid[%0d]: got %0h want 1", i - 1, o_IValid); end
        n_vectors++; if (o_IData !== exp_data[i-1]) begin n_miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i - 1, o_IData, exp_data[i-1]); end
      end
      if (i < 4) begin
        n_vectors++; if (o_IGrant !== 1'b1) begin n_miscompares++; $display("FAIL b2b_grant[%0d]: got %0h want 1", i, o_IGrant); end
        n_vectors++; if (o_MemAddress !== 32'(i)) begin n_miscompares++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, o_MemAddress, 32'(i)); end
      end
    end
    @(negedge i_Clock);
    #1;
    n_vectors++; if (o_IValid !== 1'b0) begin n_miscompares++; $display("FAIL b2b_valid_end: got %0h want 0", o_IValid); end
  endtask

  task automatic test_contention();
    logic exp_d;
    for (int i = 0; i <= 4; i++) begin
      @(negedge i_Clock);
      i_IReq = (i < 4); i_DReq = (i < 4); i_DWrite = 1'b0;
      i_IAddress = 32'h100; i_DAddress = 32'h40;
      #1;
      if (i > 0) begin
        exp_d = d_expected(i - 1);
        n_vectors++; if ({o_DValid, o_IValid} !== {exp_d, !exp_d}) begin n_miscompares++; $display("FAIL cont_valid[%0d]: got D%0b I%0b want D%0b I%0b", i - 1, o_DValid, o_IValid, exp_d, !exp_d); end
        if (exp_d) begin
          n_vectors++; if (o_DData !== 32'h11223344) begin n_miscompares++; $display("FAIL cont_ddata[%0d]: got %h want 11223344", i - 1, o_DData); end
        end else begin
          n_vectors++; if (o_IData !== 32'hDEADBEEF) begin n_miscompares++; $display("FAIL cont_idata[%0d]: got %h want deadbeef", i - 1, o_IData); end
        end
      end
      if (i < 4) begin
        exp_d = d_expected(i);
        n_vectors++; if ({o_DGrant, o_IGrant} !== {exp_d, !exp_d}) begin n_miscompares++; $display("FAIL cont_grant[%0d]: got D%0b I%0b want D%0b I%0b", i, o_DGrant, o_IGrant, exp_d, !exp_d); end
      end
    end
  endtask

  task automatic test_partial_store();
    @(negedge i_Clock);
    i_DReq = 1'b1; i_DWrite = 1'b1; i_DAddress = 32'h40; i_DByteEnable = 4'b0101; i_DData = 32'hAABBCCDD;
    #1;
    n_vectors++; if (o_DGrant !== 1'b1) begin n_miscompares++; $display("FAIL rmw_grant: got %0h want 1", o_DGrant); end
    n_vectors++; if (o_MemWriteEnable !== 1'b0) begin n_miscompares++; $display("FAIL rmw_read_we: got %0h want 0", o_MemWriteEnable); end
    n_vectors++; if (o_MemAddress !== 32'h10) begin n_miscompares++; $display("FAIL rmw_read_addr: got %h want 00000010", o_MemAddress); end
    @(negedge i_Clock);
    i_DReq = 1'b0; i_IReq = 1'b1; i_IAddress = 32'h100;
    #1;
    n_vectors++; if (o_MemWriteEnable !== 1'b1) begin n_miscompares++; $display("FAIL rmw_write_we: got %0h want 1", o_MemWriteEnable); end
    n_vectors++; if (o_MemAddress !== 32'h10) begin n_miscompares++; $display("FAIL rmw_write_addr: got %h want 00000010", o_MemAddress); end
    n_vectors++; if (o_MemDataIn !== 32'h11BB33DD) begin n_miscompares++; $display("FAIL rmw_merge: got %h want 11bb33dd", o_MemDataIn); end
    n_vectors++; if ({o_IGrant, o_DGrant} !== 2'b00) begin n_miscompares++; $display("FAIL rmw_grants_blocked: got %0b want 00", {o_IGrant, o_DGrant}); end
    n_vectors++; if (o_DValid !== 1'b0) begin n_miscompares++; $display("FAIL rmw_early_valid: got %0h want 0", o_DValid); end
    @(negedge i_Clock);
    i_IReq = 1'b0;
    #1;
    n_vectors++; if (o_DValid !== 1'b1) begin n_miscompares++; $display("FAIL rmw_ack: got %0h want 1", o_DValid); end
    n_vectors++; if (o_MemWriteEnable !== 1'b0) begin n_miscompares++; $display("FAIL rmw_done_we: got %0h want 0", o_MemWriteEnable); end
    n_vectors++; if (mem[16'h10] !== 32'h11BB33DD) begin n_miscompares++; $display("FAIL rmw_mem: got %h want 11bb33dd", mem[16'h10]); end
    @(negedge i_Clock);
    i_DReq = 1'b1; i_DWrite = 1'b0; i_DAddress = 32'h40;
    #1;
    n_vectors++; if (o_DGrant !== 1'b1) begin n_miscompares++; $display("FAIL rmw_load_grant: got %0h want 1", o_DGrant); end
    @(negedge i_Clock);
    i_DReq = 1'b0;
    #1;
    n_vectors++; if ({o_DValid, o_DData} !== {1'b1, 32'h11BB33DD}) begin n_miscompares++; $display("FAIL rmw_load: got %0b/%h want 1/11bb33dd", o_DValid, o_DData); end
  endtask

  task automatic test_zero_be_store();
    @(negedge i_Clock);
    i_DReq = 1'b1; i_DWrite = 1'b1; i_DAddress = 32'h40; i_DByteEnable = 4'h0; i_DData = 32'hFFFFFFFF;
    #1;
    n_vectors++; if ({o_DGrant, o_MemWriteEnable} !== 2'b10) begin n_miscompares++; $display("FAIL be0_grant_we: got %0b want 10", {o_DGrant, o_MemWriteEnable}); end
    @(negedge i_Clock);
    i_DReq = 1'b0;
    #1;
    n_vectors++; if ({o_DValid, o_MemWriteEnable} !== 2'b10) begin n_miscompares++; $display("FAIL be0_ack: got %0b want 10", {o_DValid, o_MemWriteEnable}); end
    n_vectors++; if (mem[16'h10] !== 32'h11BB33DD) begin n_miscompares++; $display("FAIL be0_mem: got %h want 11bb33dd", mem[16'h10]); end
  endtask

  task automatic test_full_store();
    @(negedge i_Clock);
    i_DReq = 1'b1; i_DWrite = 1'b1; i_DAddress = 32'h8; i_DByteEnable = 4'hF; i_DData = 32'hCAFEF00D;
    #1;
    n_vectors++; if ({o_DGrant, o_MemWriteEnable} !== 2'b11) begin n_miscompares++; $display("FAIL full_grant_we: got %0b want 11", {o_DGrant, o_MemWriteEnable}); end
    n_vectors++; if ({o_MemAddress, o_MemDataIn} !== {32'h2, 32'hCAFEF00D}) begin n_miscompares++; $display("FAIL full_addr_data: got %h/%h want 00000002/cafef00d", o_MemAddress, o_MemDataIn); end
    @(negedge i_Clock);
    i_DWrite = 1'b0;
    #1;
    n_vectors++; if ({o_DGrant, o_MemWriteEnable, o_DValid} !== 3'b101) begin n_miscompares++; $display("FAIL full_load_issue: got %0b want 101", {o_DGrant, o_MemWriteEnable, o_DValid}); end
    @(negedge i_Clock);
    i_DReq = 1'b0;
    #1;
    n_vectors++; if ({o_DValid, o_DData} !== {1'b1, 32'hCAFEF00D}) begin n_miscompares++; $display("FAIL full_load: got %0b/%h want 1/cafef00d", o_DValid, o_DData); end
    @(negedge i_Clock);
    #1;
    n_vectors++; if (o_DValid !== 1'b0) begin n_miscompares++; $display("FAIL full_valid_end: got %0h want 0", o_DValid); end
  endtask

  task automatic test_reset_in_rmw();
    @(negedge i_Clock);
    i_DReq = 1'b1; i_DWrite = 1'b1; i_DAddress = 32'h40; i_DByteEnable = 4'b0011; i_DData = 32'h55667788;
    #1;
    n_vectors++; if (o_DGrant !== 1'b1) begin n_miscompares++; $display("FAIL rst_rmw_grant: got %0h want 1", o_DGrant); end
    @(negedge i_Clock);
    i_DReq = 1'b0; i_IReq = 1'b1; i_IAddress = 32'h100;
    #1;
    n_vectors++; if (o_MemWriteEnable !== 1'b1) begin n_miscompares++; $display("FAIL rst_rmw_pre_we: got %0h want 1", o_MemWriteEnable); end
    i_Reset = 1'b1;
    #1;
    n_vectors++; if (o_MemWriteEnable !== 1'b0) begin n_miscompares++; $display("FAIL rst_rmw_we: got %0h want 0", o_MemWriteEnable); end
    n_vectors++; if ({o_IGrant, o_DGrant} !== 2'b00) begin n_miscompares++; $display("FAIL rst_rmw_grants: got %0b want 00", {o_IGrant, o_DGrant}); end
    @(negedge i_Clock);
    #1;
    n_vectors++; if ({o_DValid, o_IValid} !== 2'b00) begin n_miscompares++; $display("FAIL rst_rmw_valid: got %0b want 00", {o_DValid, o_IValid}); end
    n_vectors++; if (mem[16'h10] !== 32'h11BB33DD) begin n_miscompares++; $display("FAIL rst_rmw_mem: got %h want 11bb33dd", mem[16'h10]); end
    i_Reset = 1'b0;
    #1;
    n_vectors++; if ({o_IGrant, o_MemAddress} !== {1'b1, 32'h40}) begin n_miscompares++; $display("FAIL rst_rmw_idle_grant: got %0b/%h want 1/00000040", o_IGrant, o_MemAddress); end
    @(negedge i_Clock);
    i_IReq = 1'b0;
    #1;
    n_vectors++; if ({o_IValid, o_DValid, o_IData} !== {2'b10, 32'hDEADBEEF}) begin n_miscompares++; $display("FAIL rst_rmw_after: got %0b%0b/%h want 10/deadbeef", o_IValid, o_DValid, o_IData); end
    @(negedge i_Clock);
    #1;
    n_vectors++; if (mem[16'h10] !== 32'h11BB33DD) begin n_miscompares++; $display("FAIL rst_rmw_mem_final: got %h want 11bb33dd", mem[16'h10]); end
  endtask

  initial begin
    n_vectors = 0; n_miscompares = 0;
    i_Reset = 1'b1; i_IReq = 1'b0; i_IAddress = '0; i_DReq = 1'b0; i_DWrite = 1'b0;
    i_DAddress = '0; i_DByteEnable = '0; i_DData = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    preload(16'h0040, 32'hDEADBEEF);
    preload(16'h0010, 32'h11223344);
    preload(16'h0000, 32'h1111_0000);
    preload(16'h0001, 32'h2222_0001);
    preload(16'h0002, 32'h3333_0002);
    preload(16'h0003, 32'h4444_0003);
    test_reset();
    test_fetch();
    test_back_to_back();
    test_contention();
    test_partial_store();
    test_zero_be_store();
    test_full_store();
    test_reset_in_rmw();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
